// File: rtl/req_encoder_32to5_if.sv
// Request/code bundle between the cause encoder and its consumer.
// Handshake: a code moves on a rising edge where out_valid and out_ready are both high; out_code is stable while out_valid is high and out_ready is low.
interface req_encoder_32to5_if;
  logic [31:0] req;
  logic [31:0] mask;
  logic        flush;
  logic        out_ready;
  logic        out_valid;
  logic [4:0]  out_code;
  logic [31:0] pending;
  logic        any_pending;
  logic        state_dbg;

  modport master (
    input  req, mask, flush, out_ready,
    output out_valid, out_code, pending, any_pending, state_dbg
  );

  modport slave (
    output req, mask, flush, out_ready,
    input  out_valid, out_code, pending, any_pending, state_dbg
  );
endinterface

// File: rtl/req_encoder_32to5.sv
// 32-line sticky request collector that presents one selected index at a time.
// Selection is fixed lowest-index priority or round-robin after the last accepted code.
module req_encoder_32to5 #(
  parameter bit RR_MODE = 1'b0
) (
  input logic clock,
  input logic reset,
  req_encoder_32to5_if.master bus
);

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

  state_t      state, state_next;
  logic [31:0] pending_q, pending_next;
  logic [31:0] held_oh, clr, elig;
  logic [4:0]  code_q, ptr_q, start, pick, idx;
  logic        found, hs, load;

  assign held_oh = 32'd1 << code_q;
  assign hs      = (state == HOLD) && bus.out_ready;
  assign clr     = hs ? held_oh : 32'd0;
  // The held code is never a candidate for its own replacement.
  assign elig    = bus.pending & bus.mask & ((state == HOLD) ? ~held_oh : 32'hFFFF_FFFF);
  assign start   = RR_MODE ? (hs ? code_q + 5'd1 : ptr_q) : 5'd0;

  // First eligible index scanning upward from start, wrapping at 31.
  always_comb begin
    found = 1'b0;
    pick  = 5'd0;
    idx   = 5'd0;
    for (int k = 0; k < 32; k++) begin
      idx = start + k[4:0];
      if (!found && elig[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  assign bus.pending = pending_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    if (bus.flush) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: if (found) begin
          state_next = HOLD;
          load       = 1'b1;
        end
        HOLD: if (hs) begin
          if (found) load = 1'b1;
          else       state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    bus.out_valid   = (state == HOLD);
    bus.out_code    = code_q;
    bus.any_pending = |pending_q;
    bus.state_dbg   = state;
  end

  // A request on the bit being accepted re-pends it: set wins over clear.
  assign pending_next = bus.flush ? 32'd0 : ((pending_q & ~clr) | bus.req);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pending_q <= 32'd0;
      code_q    <= 5'd0;
      ptr_q     <= 5'd0;
    end else begin
      pending_q <= pending_next;
      if (load) code_q <= pick;
      if (hs && !bus.flush) ptr_q <= code_q + 5'd1;
    end
  end

endmodule

// File: tb/tb_req_encoder_32to5.sv
// Bench for both selection modes side by side, sharing one stimulus stream.
// A per-mode reference model is checked every cycle; directed literals pin the model.
module tb_req_encoder_32to5;

  logic        clock;
  logic        reset;
  logic [31:0] req;
  logic [31:0] mask;
  logic        flush;
  logic        out_ready;

  int checks_total = 0;
  int checks_passed = 0;

  req_encoder_32to5_if bus0();
  req_encoder_32to5_if bus1();

  assign bus0.req = req;
  assign bus0.mask = mask;
  assign bus0.flush = flush;
  assign bus0.out_ready = out_ready;
  assign bus1.req = req;
  assign bus1.mask = mask;
  assign bus1.flush = flush;
  assign bus1.out_ready = out_ready;

  req_encoder_32to5 #(.RR_MODE(1'b0)) dut_fixed (.clock(clock), .reset(reset), .bus(bus0));
  req_encoder_32to5 #(.RR_MODE(1'b1)) dut_rr    (.clock(clock), .reset(reset), .bus(bus1));

  // clock / reset
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // reference model: index 0 = fixed priority, index 1 = round-robin
  logic [31:0] m_pend  [2];
  logic        m_valid [2];
  logic [4:0]  m_code  [2];
  int          m_next  [2];

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 2; i++) begin
        m_pend[i] = 32'd0;
        m_valid[i] = 1'b0;
        m_code[i] = 5'd0;
        m_next[i] = 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        bit accepted;
        bit got;
        int from;
        int cand;
        int chosen;
        logic [31:0] np;
        accepted = m_valid[i] && out_ready;
        if (flush) begin
          m_pend[i] = 32'd0;
          m_valid[i] = 1'b0;
        end else begin
          from = (i == 1) ? (accepted ? (int'(m_code[i]) + 1) % 32 : m_next[i]) : 0;
          got = 1'b0;
          chosen = 0;
          for (int k = 0; k < 32; k++) begin
            cand = (from + k) % 32;
            if (!got && m_pend[i][cand] && mask[cand] && !(m_valid[i] && cand == int'(m_code[i]))) begin
              got = 1'b1;
              chosen = cand;
            end
          end
          np = m_pend[i];
          if (accepted) np[m_code[i]] = 1'b0;
          np = np | req;
          if (accepted) m_next[i] = (int'(m_code[i]) + 1) % 32;
          if (!m_valid[i] || accepted) begin
            m_valid[i] = got;
            if (got) m_code[i] = chosen[4:0];
          end
          m_pend[i] = np;
        end
      end
    end
  end

  // scoreboard helpers
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks_total++;
    if (act === exp) checks_passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic cmp(input int i, input logic v, input logic [4:0] c, input logic [31:0] p, input logic a);
    chk($sformatf("model_valid[%0d]", i), {31'd0, v}, {31'd0, m_valid[i]});
    if (m_valid[i]) chk($sformatf("model_code[%0d]", i), {27'd0, c}, {27'd0, m_code[i]});
    chk($sformatf("model_pending[%0d]", i), p, m_pend[i]);
    chk($sformatf("model_any[%0d]", i), {31'd0, a}, {31'd0, |m_pend[i]});
  endtask

  always @(negedge clock) begin
    cmp(0, bus0.out_valid, bus0.out_code, bus0.pending, bus0.any_pending);
    cmp(1, bus1.out_valid, bus1.out_code, bus1.pending, bus1.any_pending);
  end

  // driver tasks
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic both_code(input string name, input logic [4:0] c0, input logic [4:0] c1);
    chk({name, "_v0"}, {31'd0, bus0.out_valid}, 32'd1);
    chk({name, "_c0"}, {27'd0, bus0.out_code}, {27'd0, c0});
    chk({name, "_v1"}, {31'd0, bus1.out_valid}, 32'd1);
    chk({name, "_c1"}, {27'd0, bus1.out_code}, {27'd0, c1});
  endtask

  task automatic both_idle(input string name);
    chk({name, "_v0"}, {31'd0, bus0.out_valid}, 32'd0);
    chk({name, "_v1"}, {31'd0, bus1.out_valid}, 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    req = 32'hFFFF_FFFF;
    mask = 32'hFFFF_FFFF;
    flush = 1'b0;
    out_ready = 1'b0;
    #1 reset = 1'b0;

    // reset with all requests high
    tick();
    chk("rst_valid", {31'd0, bus0.out_valid}, 32'd0);
    chk("rst_pending", bus0.pending, 32'd0);
    reset = 1'b1;
    tick();
    chk("rel_pending", bus0.pending, 32'hFFFF_FFFF);
    req = 32'd0;
    tick();
    both_code("rel_first", 5'd0, 5'd0);
    flush = 1'b1;
    tick();
    flush = 1'b0;

    // single pulse on bit 13
    out_ready = 1'b1;
    req = 32'd1 << 13;
    tick();
    req = 32'd0;
    tick();
    both_code("single13", 5'd13, 5'd13);
    tick();
    both_idle("single13_after");
    chk("single13_pend", bus0.pending, 32'd0);
    chk("single13_any", {31'd0, bus0.any_pending}, 32'd0);

    // three simultaneous requests, back-to-back
    req = (32'd1 << 3) | (32'd1 << 7) | (32'd1 << 31);
    tick();
    req = 32'd0;
    tick();
    both_code("burst_a", 5'd3, 5'd31);
    tick();
    both_code("burst_b", 5'd7, 5'd3);
    tick();
    both_code("burst_c", 5'd31, 5'd7);
    tick();
    both_idle("burst_end");

    // bits 2 and 5 requested continuously
    req = (32'd1 << 2) | (32'd1 << 5);
    tick();
    tick();
    both_code("alt_a", 5'd2, 5'd2);
    tick();
    both_code("alt_b", 5'd5, 5'd5);
    tick();
    both_code("alt_c", 5'd2, 5'd2);
    tick();
    both_code("alt_d", 5'd5, 5'd5);
    req = 32'd0;
    for (int n = 0; n < 3; n++) tick();
    both_idle("alt_drain");

    // pointer wrap 31 -> 0
    req = 32'd1 | (32'd1 << 31);
    tick();
    req = 32'd0;
    tick();
    both_code("wrap_a", 5'd0, 5'd31);
    tick();
    both_code("wrap_b", 5'd31, 5'd0);
    tick();

    // backpressure
    out_ready = 1'b0;
    req = 32'd1 << 9;
    tick();
    req = 32'd0;
    tick();
    req = 32'd1 << 1;
    tick();
    req = 32'd0;
    for (int n = 0; n < 10; n++) begin
      tick();
      both_code($sformatf("bp_hold%0d", n), 5'd9, 5'd9);
    end
    out_ready = 1'b1;
    tick();
    both_code("bp_next", 5'd1, 5'd1);
    tick();

    // set wins over clear
    out_ready = 1'b0;
    req = 32'd1 << 4;
    tick();
    req = 32'd0;
    tick();
    both_code("swc_first", 5'd4, 5'd4);
    out_ready = 1'b1;
    req = 32'd1 << 4;
    tick();
    req = 32'd0;
    chk("swc_repend", bus0.pending, 32'd1 << 4);
    tick();
    both_code("swc_again", 5'd4, 5'd4);
    tick();

    // masked bit stays pending until unmasked
    mask = ~(32'd1 << 20);
    req = 32'd1 << 20;
    tick();
    req = 32'd0;
    for (int n = 0; n < 3; n++) tick();
    both_idle("mask_blocked");
    chk("mask_pend", bus1.pending, 32'd1 << 20);
    mask = 32'hFFFF_FFFF;
    tick();
    both_code("mask_open", 5'd20, 5'd20);
    tick();

    // flush during HOLD
    out_ready = 1'b0;
    req = (32'd1 << 1) | (32'd1 << 2) | (32'd1 << 3);
    tick();
    req = 32'd0;
    tick();
    both_code("flush_hold", 5'd1, 5'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    both_idle("flush_after");
    chk("flush_pend", bus0.pending, 32'd0);

    // asynchronous reset mid-HOLD
    req = 32'd1 << 6;
    tick();
    req = 32'd0;
    tick();
    both_code("arst_hold", 5'd6, 5'd6);
    #2 reset = 1'b0;
    #1;
    both_idle("arst_drop");
    tick();
    reset = 1'b1;
    tick();

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule

// File: doc/req_encoder_32to5.md
Name: req_encoder_32to5

Overview:
- Inverse of the 5-to-32 one-hot opcode decoder: collects 32 single-bit request lines and returns a 5-bit index to a consumer.
- Requests are captured into a sticky pending register.
- A fixed-priority or round-robin selector picks one eligible request and presents its code through a valid/ready handshake.
- Used as the interrupt/exception cause encoder that feeds the processor control unit.

Parameters:
- RR_MODE, 0, 0 = fixed priority (lowest index wins); 1 = round-robin starting after the last accepted index.

Ports:
- clock  in  1  single system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- req  in  32  request lines, level-sampled each rising edge; bit i high sets pending[i].
- mask  in  32  1 = request eligible for selection; 0 = held pending but not selectable.
- flush  in  1  synchronous clear of all pending bits and the output stage.
- out_ready  in  1  consumer accepts code when high with out_valid.
- out_valid  out  1  out_code is valid.
- out_code  out  5  index of the selected request.
- pending  out  32  current sticky pending register.
- any_pending  out  1  OR of pending, unmasked; combinational from the register.

Behaviour:
- Reset (reset=0, asynchronous): pending=0, out_valid=0, out_code=0, RR pointer=0, state=IDLE. Release is synchronous to the next edge.
- Eligible vector: elig = pending & mask.
- In HOLD, the held bit is excluded from elig.
- Pending update at each edge:
  - pending_next = (pending & ~clr) | req.
  - clr is a one-hot of out_code when out_valid & out_ready; otherwise 0.
  - Set wins over clear on the same bit in the same cycle: the request is re-pended.
- States:
  - IDLE (out_valid=0): if elig != 0, load out_code = select(elig), go to HOLD; otherwise stay in IDLE.
  - HOLD (out_valid=1): out_code is stable while out_ready=0. Mask changes do not alter or withdraw the held code.
  - On handshake in HOLD: clear the held bit. If elig (held bit excluded, computed from the pre-edge pending) != 0, load the next code in the same edge and stay in HOLD (back-to-back, no bubble). Otherwise go to IDLE.
- Latency: req high at edge k → pending at edge k → out_valid high after edge k+1. Requests arriving at edge k are never selectable before edge k+1.
- Selection:
  - RR_MODE=0: lowest set index of elig.
  - RR_MODE=1: first set index at or above ptr, wrapping 31→0. On each handshake, ptr = out_code+1 mod 32; 31 wraps to 0.
- flush=1 at an edge:
  - pending=0, out_valid=0, state=IDLE; ptr unchanged.
  - flush overrides req in that cycle; req is dropped.
  - flush overrides a handshake in that cycle.
- Masking a pending bit keeps it pending indefinitely; unmasking makes it eligible on the next IDLE or HOLD reload.
- Reset mid-HOLD: out_valid drops immediately (asynchronous); the code is lost.
- out_code with out_valid=0 holds its last value (0 after reset); the consumer must not use it.

Test Plan:
- Reset with req=32'hFFFF_FFFF, mask=all ones → out_valid=0, pending=0 while reset=0. First edge after release sets pending=FFFF_FFFF. out_valid=1, out_code=0 one edge later.
- RR_MODE=0, single req pulse bit 13, out_ready=1 → out_code=13 for exactly one cycle; pending returns to 0; any_pending=0.
- RR_MODE=0, req pulses bits 3, 7 and 31 together, out_ready=1 → codes 3, 7, 31 on three consecutive cycles, no bubbles, then out_valid=0.
- RR_MODE=1, bits 2 and 5 permanently requested, out_ready=1 → codes alternate 2, 5, 2, 5.
- RR_MODE=1 with ptr wrap: accept bit 31, bit 0 pending → next code=0.
- Backpressure: out_ready=0 for 10 cycles with bit 9 held and bit 1 newly requested → out_code stays 9. After ready, next code=1.
- Set-wins-clear: req[4] high in the handshake cycle of code 4 → pending[4]=1 after the edge; code 4 is presented again.
- Flush during HOLD with 3 pending bits → out_valid=0 and pending=0 after the edge. Reset asserted mid-HOLD → out_valid drops without a clock edge.
